// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - register map and status bit positions for the UART MMIO controller
package uart_mmio_pkg;

    localparam int RX_DEPTH_DEF = 4;

    // Word-aligned byte offsets within the MMIO page
    localparam logic [4:0] ADDR_STATUS    = 5'h00;
    localparam logic [4:0] ADDR_RX_DATA   = 5'h04;
    localparam logic [4:0] ADDR_TX_DATA   = 5'h08;
    localparam logic [4:0] ADDR_CYCLE_CNT = 5'h10;
    localparam logic [4:0] ADDR_INSTR_CNT = 5'h14;
    localparam logic [4:0] ADDR_CNT_RST   = 5'h18;

    // STATUS register bit positions
    localparam int ST_TX_READY   = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_TX_OVERRUN = 2;
    localparam int ST_RX_CNT_LSB = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - small synchronous FIFO buffering bytes from the UART receiver
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Requests that would over- or under-run the buffer are ignored here as well
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// rtl/uart_mmio_ctrl.sv - MMIO register front-end sequencing the UART handshakes
module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter int RX_DEPTH = RX_DEPTH_DEF,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  mmio_addr,
    input  logic        mmio_re,
    input  logic        mmio_we,
    input  logic [31:0] mmio_wdata,
    output logic [31:0] mmio_rdata,
    input  logic        inst_retired,
    output logic [7:0]  uart_din,
    output logic        uart_din_valid,
    input  logic        uart_din_ready,
    input  logic [7:0]  uart_dout,
    input  logic        uart_dout_valid,
    output logic        uart_dout_ready
);

    localparam int CW = $clog2(RX_DEPTH) + 1;

    logic [31:0]      r_rdata;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;
    logic             r_tx_overrun;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    logic [4:0]       w_addr;
    logic [7:0]       w_fifo_dout;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CW-1:0]    w_fifo_count;
    logic             w_push;
    logic             w_pop;
    logic             w_tx_hs;
    logic             w_tx_wr;
    logic             w_st_wr;
    logic             w_cnt_rst;
    logic [31:0]      w_status;
    logic [31:0]      w_rd_val;

    assign w_addr    = {mmio_addr[4:2], 2'b00};
    assign w_push    = uart_dout_valid & ~w_fifo_full;
    assign w_pop     = mmio_re & (w_addr == ADDR_RX_DATA) & ~w_fifo_empty;
    assign w_tx_hs   = r_tx_valid & uart_din_ready;
    assign w_tx_wr   = mmio_we & (w_addr == ADDR_TX_DATA);
    assign w_st_wr   = mmio_we & (w_addr == ADDR_STATUS);
    assign w_cnt_rst = mmio_we & (w_addr == ADDR_CNT_RST);

    assign mmio_rdata      = r_rdata;
    assign uart_din        = r_tx_data;
    assign uart_din_valid  = r_tx_valid;
    assign uart_dout_ready = ~w_fifo_full;

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (uart_dout),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // Assemble STATUS from live state; rx_count occupies a 4-bit field
    always_comb begin
        w_status                        = '0;
        w_status[ST_TX_READY]           = ~r_tx_valid;
        w_status[ST_RX_VALID]           = ~w_fifo_empty;
        w_status[ST_TX_OVERRUN]         = r_tx_overrun;
        w_status[ST_RX_CNT_LSB +: 4]    = 4'(w_fifo_count);
    end

    // Read mux sees pre-update state, so a same-cycle write or pop is not visible
    always_comb begin
        w_rd_val = '0;
        case (w_addr)
            ADDR_STATUS:    w_rd_val = w_status;
            ADDR_RX_DATA:   w_rd_val = w_fifo_empty ? 32'd0 : {24'd0, w_fifo_dout};
            ADDR_CYCLE_CNT: w_rd_val = 32'(r_cyc_cnt);
            ADDR_INSTR_CNT: w_rd_val = 32'(r_instr_cnt);
            default:        w_rd_val = '0;
        endcase
    end

    // Registered load data, held between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (mmio_re) begin
            r_rdata <= w_rd_val;
        end
    end

    // TX holding register: a store that coincides with the handshake still lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_tx_overrun <= 1'b0;
        end else begin
            if (w_tx_wr && (!r_tx_valid || w_tx_hs)) begin
                r_tx_data  <= mmio_wdata[7:0];
                r_tx_valid <= 1'b1;
            end else if (w_tx_hs) begin
                r_tx_valid <= 1'b0;
            end
            if (w_tx_wr && r_tx_valid && !w_tx_hs) begin
                r_tx_overrun <= 1'b1;
            end else if (w_st_wr && mmio_wdata[ST_TX_OVERRUN]) begin
                r_tx_overrun <= 1'b0;
            end
        end
    end

    // Free-running counters; a CNT_RST store overrides the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt   <= '0;
            r_instr_cnt <= '0;
        end else if (w_cnt_rst) begin
            r_cyc_cnt   <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
            if (inst_retired) r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb/tb_uart_mmio_ctrl.sv - self-checking bench with queue-based reference model
module tb_uart_mmio_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  mmio_addr = '0;
    logic        mmio_re = 1'b0;
    logic        mmio_we = 1'b0;
    logic [31:0] mmio_wdata = '0;
    logic        inst_retired = 1'b0;
    logic        uart_din_ready = 1'b0;
    logic [7:0]  uart_dout = '0;
    logic        uart_dout_valid = 1'b0;

    wire  [31:0] rdata;
    wire  [31:0] rdata2;
    wire  [7:0]  din;
    wire  [7:0]  din2;
    wire         din_v;
    wire         din_v2;
    wire         dout_rdy;
    wire         dout_rdy2;

    int tests = 0;
    int fails = 0;

    uart_mmio_ctrl #(.RX_DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mmio_addr(mmio_addr), .mmio_re(mmio_re),
        .mmio_we(mmio_we), .mmio_wdata(mmio_wdata), .mmio_rdata(rdata),
        .inst_retired(inst_retired), .uart_din(din), .uart_din_valid(din_v),
        .uart_din_ready(uart_din_ready), .uart_dout(uart_dout),
        .uart_dout_valid(uart_dout_valid), .uart_dout_ready(dout_rdy)
    );

    // Narrow-counter instance sharing the same stimulus, used to observe wrap-around
    uart_mmio_ctrl #(.RX_DEPTH(DEPTH), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .mmio_addr(mmio_addr), .mmio_re(mmio_re),
        .mmio_we(mmio_we), .mmio_wdata(mmio_wdata), .mmio_rdata(rdata2),
        .inst_retired(inst_retired), .uart_din(din2), .uart_din_valid(din_v2),
        .uart_din_ready(uart_din_ready), .uart_dout(uart_dout),
        .uart_dout_valid(uart_dout_valid), .uart_dout_ready(dout_rdy2)
    );

    always #5 clk = ~clk;

    // Reference model state
    byte unsigned    m_q[$];
    bit              m_tx_v = 1'b0;
    logic [7:0]      m_tx_d = '0;
    bit              m_ovr = 1'b0;
    longint unsigned m_cyc = 0;
    longint unsigned m_ins = 0;
    logic [31:0]     m_rd = '0;
    logic [31:0]     m_rd4 = '0;
    logic [4:0]      m_a;
    bit              m_full;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input int w);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        int n = m_q.size();
        case (a)
            5'h00:   return 32'((m_tx_v ? 0 : 1) + (n != 0 ? 2 : 0) + (m_ovr ? 4 : 0) + (n % 16) * 16);
            5'h04:   return (n != 0) ? 32'(m_q[0]) : 32'd0;
            5'h10:   return 32'(m_cyc & mask);
            5'h14:   return 32'(m_ins & mask);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_tx_v = 1'b0; m_tx_d = '0; m_ovr = 1'b0;
            m_cyc = 0; m_ins = 0; m_rd = '0; m_rd4 = '0;
        end else begin
            m_a    = {mmio_addr[4:2], 2'b00};
            m_full = (m_q.size() == DEPTH);
            if (mmio_re) begin
                m_rd  = model_read(m_a, 32);
                m_rd4 = model_read(m_a, 4);
            end
            if (mmio_re && m_a == 5'h04 && m_q.size() > 0) void'(m_q.pop_front());
            if (uart_dout_valid && !m_full) m_q.push_back(uart_dout);
            if (m_tx_v && uart_din_ready) m_tx_v = 1'b0;
            if (mmio_we && m_a == 5'h08) begin
                if (!m_tx_v) begin
                    m_tx_d = mmio_wdata[7:0];
                    m_tx_v = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            if (mmio_we && m_a == 5'h00 && mmio_wdata[2]) m_ovr = 1'b0;
            if (mmio_we && m_a == 5'h18) begin
                m_cyc = 0;
                m_ins = 0;
            end else begin
                m_cyc++;
                if (inst_retired) m_ins++;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_din_valid", {31'd0, din_v}, {31'd0, m_tx_v});
        if (m_tx_v) chk("cmp_din", {24'd0, din}, {24'd0, m_tx_d});
        chk("cmp_dout_ready", {31'd0, dout_rdy}, {31'd0, m_q.size() != DEPTH});
        chk("cmp_rdata", rdata, m_rd);
        chk("cmp_rdata_w4", rdata2, m_rd4);
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        mmio_addr = a; mmio_wdata = d; mmio_we = 1'b1;
        @(negedge clk);
        mmio_we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        mmio_addr = a; mmio_re = 1'b1;
        @(negedge clk);
        mmio_re = 1'b0;
        d = rdata;
    endtask

    logic [31:0] d;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_din_valid", {31'd0, din_v}, 32'd0);
        chk("reset_dout_ready", {31'd0, dout_rdy}, 32'd1);
        chk("reset_din", {24'd0, din}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rst_n = 1'b1;

        // TX hold, overrun, clear, handshake
        uart_din_ready = 1'b0;
        wr(5'h08, 32'h41);
        repeat (5) begin
            chk("tx_valid_hold", {31'd0, din_v}, 32'd1);
            chk("tx_din_hold", {24'd0, din}, 32'h41);
            @(negedge clk);
        end
        rd(5'h00, d); chk("status_tx_busy", d, 32'h0);
        wr(5'h08, 32'h42);
        chk("tx_din_after_ovr", {24'd0, din}, 32'h41);
        rd(5'h00, d); chk("status_ovr", d, 32'h4);
        wr(5'h00, 32'h4);
        rd(5'h00, d); chk("status_ovr_clr", d, 32'h0);
        uart_din_ready = 1'b1;
        @(negedge clk);
        uart_din_ready = 1'b0;
        chk("tx_valid_drop", {31'd0, din_v}, 32'd0);
        rd(5'h00, d); chk("status_tx_ready", d, 32'h1);

        // RX fill to full, drain, empty read
        uart_dout_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uart_dout = 8'(8'h10 + i);
            @(negedge clk);
        end
        chk("rx_full_ready", {31'd0, dout_rdy}, 32'd0);
        uart_dout = 8'h14;
        @(negedge clk);
        uart_dout_valid = 1'b0;
        rd(5'h00, d); chk("status_rx_full", d, 32'h43);
        for (int i = 0; i < 4; i++) begin
            rd(5'h04, d); chk("rx_order", d, 32'(32'h10 + i));
        end
        rd(5'h04, d); chk("rx_empty_read", d, 32'h0);
        rd(5'h00, d); chk("status_rx_empty", d, 32'h1);

        // Push and pop in the same cycle at count 2
        uart_dout_valid = 1'b1;
        uart_dout = 8'h20; @(negedge clk);
        uart_dout = 8'h21; @(negedge clk);
        uart_dout = 8'h22;
        rd(5'h04, d);
        uart_dout_valid = 1'b0;
        chk("rx_pushpop_head", d, 32'h20);
        rd(5'h00, d); chk("status_pushpop", d, 32'h23);
        rd(5'h04, d); chk("rx_pp_1", d, 32'h21);
        rd(5'h04, d); chk("rx_pp_2", d, 32'h22);

        // Counters
        wr(5'h18, 32'h0);
        rd(5'h10, d); chk("cyc_after_rst", d, 32'd0);
        rd(5'h10, d); chk("cyc_next", d, 32'd1);
        repeat (7) begin
            inst_retired = 1'b1;
            @(negedge clk);
        end
        inst_retired = 1'b0;
        rd(5'h14, d); chk("instr_7", d, 32'd7);
        inst_retired = 1'b1;
        wr(5'h18, 32'h0);
        inst_retired = 1'b0;
        rd(5'h14, d); chk("instr_rst_wins", d, 32'd0);
        wr(5'h18, 32'h0);
        repeat (15) @(negedge clk);
        rd(5'h10, d);
        chk("cyc_w4_max", rdata2, 32'hF);
        chk("cyc_15", d, 32'd15);
        rd(5'h10, d);
        chk("cyc_w4_wrap", rdata2, 32'h0);
        chk("cyc_16", d, 32'd16);

        // Simultaneous read and write of STATUS returns pre-clear value
        wr(5'h08, 32'h55);
        wr(5'h08, 32'h56);
        mmio_addr = 5'h00; mmio_wdata = 32'h4; mmio_re = 1'b1; mmio_we = 1'b1;
        @(negedge clk);
        mmio_re = 1'b0; mmio_we = 1'b0;
        chk("status_rw_pre", rdata, 32'h4);
        rd(5'h00, d); chk("status_rw_post", d, 32'h0);

        // Reset mid-traffic with TX pending and RX data buffered
        uart_dout = 8'h33; uart_dout_valid = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_din_valid", {31'd0, din_v}, 32'd0);
        chk("midrst_dout_ready", {31'd0, dout_rdy}, 32'd1);
        uart_dout_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(5'h00, d); chk("midrst_status", d, 32'h1);
        rd(5'h10, d); chk("midrst_cyc", d, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            mmio_re         = ($urandom_range(0, 2) == 0);
            mmio_we         = ($urandom_range(0, 3) == 0);
            mmio_addr       = 5'($urandom);
            mmio_wdata      = $urandom;
            inst_retired    = 1'($urandom_range(0, 1));
            uart_din_ready  = ($urandom_range(0, 3) == 0);
            uart_dout_valid = 1'($urandom_range(0, 1));
            uart_dout       = 8'($urandom);
            if (i == 2000) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        mmio_re = 1'b0; mmio_we = 1'b0; uart_dout_valid = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
